// File: rtl/life_pkg.sv
// Shared constants and state encoding for the game-of-life cell core.
// Holds the default B3/S23 rules and the neighbour-count ceiling.
package life_pkg;

  localparam logic [8:0] LIFE_RULE_B3  = 9'b000001000;
  localparam logic [8:0] LIFE_RULE_S23 = 9'b000001100;
  localparam int         NBR_MAX       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } life_state_t;

endpackage

// File: rtl/life_rule_lut.sv
// Birth/survive lookup for one cell.
// Counts above the neighbour ceiling force a dead result and flag an error.
module life_rule_lut
  import life_pkg::*;
#(
  parameter logic [8:0] RULE_BIRTH   = LIFE_RULE_B3,
  parameter logic [8:0] RULE_SURVIVE = LIFE_RULE_S23
) (
  input  logic       alive,
  input  logic [3:0] cnt,
  output logic       next,
  output logic       err
);

  // Pick the rule vector by current state; reject impossible counts.
  always_comb begin
    next = 1'b0;
    err  = 1'b0;
    if (cnt > 4'(NBR_MAX)) begin
      err = 1'b1;
    end else if (alive) begin
      next = RULE_SURVIVE[cnt];
    end else begin
      next = RULE_BIRTH[cnt];
    end
  end

endmodule

// File: rtl/life_cell_ctrl.sv
// Two-phase (evaluate/commit) cell core with a 1-bit scan path.
// Optional stable-cell detect: LIFE_CELL_CTRL_STABLE_DET_EN.
module life_cell_ctrl
  import life_pkg::*;
#(
  parameter int         GEN_W        = 16,
  parameter logic [8:0] RULE_BIRTH   = LIFE_RULE_B3,
  parameter logic [8:0] RULE_SURVIVE = LIFE_RULE_S23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       nbr_cnt_i,
  input  logic             step_i,
  input  logic             commit_i,
  input  logic             scan_en_i,
  input  logic             scan_in_i,
  output logic             scan_out_o,
  output logic             alive_o,
  output logic             ready_o,
  output logic             eval_done_o,
  output logic [GEN_W-1:0] gen_o,
`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
  output logic             stable_o,
`endif
  output logic             err_o
);

  life_state_t      state_q, state_d;
  logic             alive_q, alive_d;
  logic             next_q, next_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             err_q, err_d;
  logic             lut_next, lut_err;

  life_rule_lut #(
    .RULE_BIRTH  (RULE_BIRTH),
    .RULE_SURVIVE(RULE_SURVIVE)
  ) u_lut (
    .alive(alive_q),
    .cnt  (nbr_cnt_i),
    .next (lut_next),
    .err  (lut_err)
  );

`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
  logic stable_q, stable_d;
`endif

  // Next-state and datapath updates; scan beats step in IDLE.
  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    next_d  = next_q;
    gen_d   = gen_q;
    err_d   = err_q;
`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
    stable_d = stable_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (scan_en_i) begin
          alive_d = scan_in_i;
`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
          stable_d = 1'b0;
`endif
        end else if (step_i) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        next_d = lut_next;
        if (lut_err) err_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (commit_i) begin
          alive_d = next_q;
          gen_d   = gen_q + 1'b1;
`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
          stable_d = (next_q == alive_q);
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      next_q  <= 1'b0;
      gen_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      next_q  <= next_d;
      gen_q   <= gen_d;
      err_q   <= err_d;
    end
  end

`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
  // Stable flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_q <= 1'b0;
    else     stable_q <= stable_d;
  end

  assign stable_o = stable_q;
`endif

  assign alive_o     = alive_q;
  assign scan_out_o  = alive_q;
  assign ready_o     = (state_q == IDLE);
  assign eval_done_o = (state_q == HOLD);
  assign gen_o       = gen_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_life_cell_ctrl.sv
// Randomized self-checking bench for life_cell_ctrl against a B3/S23 model.
// A second instance with GEN_W=2 checks generation wrap.
module tb_life_cell_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  nbr_cnt_i = '0;
  logic        step_i = 1'b0;
  logic        commit_i = 1'b0;
  logic        scan_en_i = 1'b0;
  logic        scan_in_i = 1'b0;

  logic        scan_out_o, alive_o, ready_o, eval_done_o, err_o;
  logic [15:0] gen_o;
  logic        scan_out2, alive2, ready2, eval_done2, err2;
  logic [1:0]  gen2;
`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
  logic        stable_o, stable2;
`endif

  life_cell_ctrl dut (
    .clk(clk), .rst(rst), .nbr_cnt_i(nbr_cnt_i),
    .step_i(step_i), .commit_i(commit_i),
    .scan_en_i(scan_en_i), .scan_in_i(scan_in_i),
    .scan_out_o(scan_out_o), .alive_o(alive_o),
    .ready_o(ready_o), .eval_done_o(eval_done_o),
    .gen_o(gen_o),
`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
    .stable_o(stable_o),
`endif
    .err_o(err_o)
  );

  life_cell_ctrl #(.GEN_W(2)) dut2 (
    .clk(clk), .rst(rst), .nbr_cnt_i(nbr_cnt_i),
    .step_i(step_i), .commit_i(commit_i),
    .scan_en_i(scan_en_i), .scan_in_i(scan_in_i),
    .scan_out_o(scan_out2), .alive_o(alive2),
    .ready_o(ready2), .eval_done_o(eval_done2),
    .gen_o(gen2),
`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
    .stable_o(stable2),
`endif
    .err_o(err2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_alive, m_next, m_err, m_stable;
  int m_gen;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rule(input bit a, input int c);
    if (c > 8) return 1'b0;
    if (a) return (c == 2 || c == 3);
    return (c == 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_alive = 0; m_next = 0; m_err = 0; m_stable = 0; m_gen = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".alive"}, alive_o, m_alive);
    check({tag, ".scan"}, scan_out_o, m_alive);
    check({tag, ".gen"}, gen_o, m_gen % 65536);
    check({tag, ".gen2"}, gen2, m_gen % 4);
    check({tag, ".err"}, err_o, m_err);
    check({tag, ".alive2"}, alive2, m_alive);
`ifdef LIFE_CELL_CTRL_STABLE_DET_EN
    check({tag, ".stable"}, stable_o, m_stable);
`endif
  endtask

  task automatic do_scan(input bit b);
    scan_en_i = 1; scan_in_i = b;
    tick();
    scan_en_i = 0;
    m_alive = b; m_stable = 0;
    check("scan.ready", ready_o, 1);
    check_all("scan");
  endtask

  // Step into HOLD, optionally disturb it, then commit.
  task automatic do_gen(input int cnt, input bit noisy);
    step_i = 1; nbr_cnt_i = 4'(cnt);
    tick();
    step_i = 0;
    check("eval.ready", ready_o, 0);
    check("eval.done", eval_done_o, 0);
    tick();
    m_next = rule(m_alive, cnt);
    if (cnt > 8) m_err = 1;
    check("hold.done", eval_done_o, 1);
    check_all("hold");
    if (noisy) begin
      nbr_cnt_i = 4'($urandom_range(0, 15));
      step_i = 1;
      scan_en_i = 1'($urandom);
      scan_in_i = 1'($urandom);
      tick();
      step_i = 0; scan_en_i = 0;
      check("noise.done", eval_done_o, 1);
      check_all("noise");
    end
    commit_i = 1;
    step_i = 1'($urandom);
    nbr_cnt_i = 4'($urandom_range(0, 15));
    tick();
    commit_i = 0; step_i = 0;
    m_stable = (m_next == m_alive);
    m_alive = m_next;
    m_gen++;
    check("commit.ready", ready_o, 1);
    check("commit.done", eval_done_o, 0);
    check_all("commit");
  endtask

  initial begin
    model_reset();
    tick(); tick();
    check("rst.ready", ready_o, 1);
    check("rst.done", eval_done_o, 0);
    check_all("rst");
    rst = 0;
    tick();

    // Survive with 2, die with 4.
    do_scan(1);
    do_gen(2, 0);
    do_gen(4, 0);
    // Birth with 3, count disturbed during HOLD.
    do_gen(3, 1);
    // Out-of-range count on a live cell.
    do_gen(9, 0);
    do_gen(3, 0);
    check("err.sticky", err_o, 1);

    // Step with scan: scan wins, no evaluation.
    step_i = 1; scan_en_i = 1; scan_in_i = 1;
    tick();
    step_i = 0; scan_en_i = 0;
    m_alive = 1; m_stable = 0;
    check("stepscan.ready", ready_o, 1);
    check_all("stepscan");
    tick();
    check("stepscan.ready2", ready_o, 1);
    check("stepscan.done", eval_done_o, 0);

    // Commit in IDLE is ignored.
    commit_i = 1;
    tick();
    commit_i = 0;
    check("idlecommit.ready", ready_o, 1);
    check_all("idlecommit");

    // Async reset mid-HOLD with a pending birth.
    do_scan(0);
    step_i = 1; nbr_cnt_i = 4'd3;
    tick();
    step_i = 0;
    tick();
    check("prerst.done", eval_done_o, 1);
    #2 rst = 1;
    #1;
    model_reset();
    check("arst.ready", ready_o, 1);
    check("arst.done", eval_done_o, 0);
    check_all("arst");
    tick();
    rst = 0;
    tick();

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: do_scan(1'($urandom));
        1: begin
          step_i = 1; scan_en_i = 1; scan_in_i = 1'($urandom);
          tick();
          step_i = 0; scan_en_i = 0;
          m_alive = scan_in_i; m_stable = 0;
          check("rnd.stepscan", eval_done_o, 0);
          check_all("rnd.stepscan");
        end
        2: begin
          commit_i = 1;
          tick();
          commit_i = 0;
          check_all("rnd.idlecommit");
        end
        3: do_gen(($urandom_range(0, 15) == 0) ? $urandom_range(9, 15)
                                                : $urandom_range(0, 8),
                  1'($urandom));
        default: do_gen($urandom_range(0, 8), 1'($urandom));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
